// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit multiplexed display path
// (scan controller, hex mux, segment decoder).
package display_pkg;

    localparam int NUM_DIGITS      = 4;
    localparam int DEF_DIV         = 100000;
    localparam int DEF_BLANK       = 16;
    localparam int DEF_BLINK_SCANS = 125;

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } scan_state_e;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] sel);
        return NUM_DIGITS'(1) << sel;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot timer: counts 0..DIV-1 while enabled and flags the slot
// start, the last blanking cycle and the last cycle of the slot.
module slot_timer
    import display_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_slot_start,
    output logic o_active_start,
    output logic o_slot_end
);

    localparam int            CW         = $clog2(DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    logic [CW-1:0] r_slot_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
        end else if (!i_enable || (r_slot_cnt == SLOT_LAST)) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + CW'(1);
        end
    end

    assign o_slot_start   = i_enable && (r_slot_cnt == '0);
    // Fires in the last BLANK cycle, so ACTIVE begins exactly at slot_cnt=BLANK.
    assign o_active_start = i_enable && (r_slot_cnt == BLANK_LAST);
    // Register-only decode: drives scan_tick and the digit advance.
    assign o_slot_end     = (r_slot_cnt == SLOT_LAST);

endmodule

// File: rtl/display_scan.sv
// Multiplexed 4-digit display scanner with per-slot anode blanking,
// leading-zero suppression, decimal point and digit blink.
//   state     | meaning
//   ST_BLANK  | dead time after a select change, all anodes off
//   ST_ACTIVE | selected digit lit per latched enable/blink/dp
module display_scan
    import display_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int BLANK       = DEF_BLANK,
    parameter int BLINK_SCANS = DEF_BLINK_SCANS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [1:0]            digit_sel,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  dp_n,
    output logic                  scan_tick
);

    localparam int            SW        = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

    logic                  w_slot_start;
    logic                  w_active_start;
    logic                  w_slot_end;
    scan_state_e           r_state;
    scan_state_e           w_state_nxt;
    logic [1:0]            r_digit_sel;
    logic [SW-1:0]         r_scan_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_en_q;
    logic [NUM_DIGITS-1:0] r_dpq;
    logic [NUM_DIGITS-1:0] r_blink_q;
    logic [NUM_DIGITS-1:0] w_sel_onehot;
    logic                  w_lit;

    slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .o_slot_start   (w_slot_start),
        .o_active_start (w_active_start),
        .o_slot_end     (w_slot_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_BLANK;
        end else begin
            case (r_state)
                ST_BLANK:  if (w_active_start) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (w_slot_end)     w_state_nxt = ST_BLANK;
                default:                       w_state_nxt = ST_BLANK;
            endcase
        end
    end

    // Blink phase flips after every BLINK_SCANS complete 4-digit scans.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_sel   <= 2'd0;
            r_scan_cnt    <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_end) begin
            r_digit_sel <= r_digit_sel + 2'd1;
            if (r_digit_sel == 2'd3) begin
                if (r_scan_cnt == SCAN_LAST) begin
                    r_scan_cnt    <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_scan_cnt <= r_scan_cnt + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q    <= '0;
            r_dpq     <= '0;
            r_blink_q <= '0;
        end else if (w_slot_start) begin
            r_en_q    <= digit_en;
            r_dpq     <= dp_in;
            r_blink_q <= blink_mask;
        end
    end

    assign w_sel_onehot = digit_onehot(r_digit_sel);
    assign w_lit        = (r_state == ST_ACTIVE) && r_en_q[r_digit_sel]
                          && !(r_blink_phase && r_blink_q[r_digit_sel]);

    assign digit_sel = r_digit_sel;
    assign an_n      = w_lit ? ~w_sel_onehot : '1;
    assign dp_n      = ~(w_lit && r_dpq[r_digit_sel]);
    assign scan_tick = w_slot_end;

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 100000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK, default 16, dead cycles at the start of each slot (legal range 1..DIV-2).
REQ-003 The block SHALL have parameter BLINK_SCANS, default 125, full 4-digit scans per blink half-period (minimum 1).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit: scanning runs while high.
REQ-007 Port digit_en, input, 4 bits: per-digit display enable, used for leading-zero blanking.
REQ-008 Port dp_in, input, 4 bits: per-digit decimal point request.
REQ-009 Port blink_mask, input, 4 bits: digits that blink.
REQ-010 Port digit_sel, output, 2 bits: nibble select driven to the downstream 16-to-4 hex mux.
REQ-011 Port an_n, output, 4 bits: active-low anode enables.
REQ-012 Port dp_n, output, 1 bit: active-low decimal point.
REQ-013 Port scan_tick, output, 1 bit: one-cycle pulse on each digit advance.

Function
REQ-014 slot_cnt SHALL count 0..DIV-1 while enable=1 and wrap to 0 after DIV-1.
REQ-015 In the cycle where slot_cnt=DIV-1, the block SHALL increment digit_sel modulo 4 (3 wraps to 0) on the next edge, and scan_tick SHALL be 1 for exactly that cycle.
REQ-016 The block SHALL implement two states: BLANK while slot_cnt<BLANK, and ACTIVE while BLANK<=slot_cnt<=DIV-1.
REQ-017 In BLANK, an_n SHALL be 4'b1111 and dp_n SHALL be 1 (ghosting suppression after a select change).
REQ-018 In ACTIVE, an_n[i] SHALL be 0 only when i=digit_sel, en_q[i]=1, and not (blink_phase=1 and blink_q[i]=1).
REQ-019 dp_n SHALL be 0 only when the selected anode is on and dpq[digit_sel]=1.
REQ-020 When slot_cnt=0, the block SHALL register digit_en, dp_in and blink_mask into en_q, dpq and blink_q; changes mid-slot SHALL take effect at the next slot only.
REQ-021 scan_cnt SHALL increment when digit_sel wraps 3->0; on reaching BLINK_SCANS-1 it SHALL clear and toggle blink_phase.
REQ-022 With enable=0: slot_cnt SHALL clear to 0, digit_sel and blink state SHALL hold, state SHALL be BLANK, an_n=4'b1111, dp_n=1, scan_tick=0.
REQ-023 When enable rises, the block SHALL resume at slot_cnt=0 with the held digit_sel, so that a full BLANK period precedes the first lit cycle.
REQ-024 an_n, dp_n and scan_tick SHALL be decoded from registers only, with no combinational path from any input to any output.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously set slot_cnt=0, digit_sel=0, scan_cnt=0, blink_phase=0, en_q=dpq=blink_q=0, state=BLANK.
REQ-026 During and immediately after reset, outputs SHALL be an_n=4'b1111, dp_n=1, scan_tick=0, digit_sel=0.
REQ-027 Reset asserted mid-slot SHALL extinguish all anodes immediately; the first slot after release SHALL start at digit 0 in BLANK.

Structure
REQ-028 Shared package display_pkg SHALL hold NUM_DIGITS=4, the state encoding (BLANK, ACTIVE), and the default DIV/BLANK/BLINK_SCANS values, for reuse by the mux and segment decoder.
REQ-029 Sub-module slot_timer SHALL contain slot_cnt, produce slot_start (slot_cnt=0), active and slot_end strobes, and be parameterised by DIV and BLANK.
REQ-030 Target size is 120-400 lines of RTL across display_scan and slot_timer.

Verification
REQ-031 Settings DIV=8, BLANK=2, BLINK_SCANS=2, digit_en=4'hF, enable=1 -> digit_sel steps 0,1,2,3,0 every 8 cycles; an_n=1111 for 2 cycles, then 1110 for 6 cycles (digit 0); scan_tick pulses every 8 cycles.
REQ-032 digit_en=4'b0011 -> an_n stays 1111 in the digit-2 and digit-3 slots while digit_sel still advances.
REQ-033 blink_mask=4'b0001 -> digit 0 is lit for scans 0-1, dark for scans 2-3, and lit again for scans 4-5; other digits are unaffected.
REQ-034 dp_in changes from 0 to 4'b0010 midway through the digit-1 slot -> dp_n stays 1 in that slot and is 0 during the ACTIVE part of the next digit-1 slot.
REQ-035 enable drops at slot_cnt=5 of digit 2, then rises 10 cycles later -> an_n=1111 at once, digit_sel holds 2, and 2 BLANK cycles occur before an_n=1011.
REQ-036 rst_n pulses low for 1 cycle at slot_cnt=4 of digit 3 -> an_n=1111 asynchronously, digit_sel=0, and the next lit pattern is 1110 after 2 BLANK cycles.
